// File: rtl/piso_stream_ser_if.sv
`default_nettype none
// ============================================================================
//  Module      : piso_stream_ser_if
//  Description : Word-side and bit-side signal bundle for piso_stream_ser.
//                The master side feeds words and the bit-time strobe;
//                the slave side (the serializer) returns the serial bit
//                stream and FIFO status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface piso_stream_ser_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    // Word side
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_last;
    logic                  in_ready;

    // Bit side
    logic                  ser_en;
    logic                  ser_data;
    logic                  ser_valid;
    logic                  ser_stuff;
    logic                  ser_last;

    // Status
    logic [LW-1:0]         fifo_level;

    modport master (
        output in_data, in_valid, in_last, ser_en,
        input  in_ready, ser_data, ser_valid, ser_stuff, ser_last, fifo_level
    );

    modport slave (
        input  in_data, in_valid, in_last, ser_en,
        output in_ready, ser_data, ser_valid, ser_stuff, ser_last, fifo_level
    );
endinterface
`default_nettype wire

// File: rtl/piso_stream_ser.sv
`default_nettype none
// ============================================================================
//  Module      : piso_stream_ser
//  Description : Parallel-in/serial-out streaming serializer. Words are
//                buffered in a small FIFO and shifted out back-to-back, one
//                bit per ser_en strobe, in LSB- or MSB-first order, with
//                optional USB-style bit stuffing (a 0 after STUFF_RUN ones).
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_stream_ser #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int LSB_FIRST  = 1,
    parameter int STUFF_EN   = 1,
    parameter int STUFF_RUN  = 6
) (
    input  wire logic          clk,
    input  wire logic          rst,
    piso_stream_ser_if.slave   bus
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    localparam logic [LW-1:0] C_DEPTH    = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] C_WIDTH    = CW'(DATA_WIDTH);
    localparam logic [3:0]    C_RUN      = 4'(STUFF_RUN);
    localparam bit            C_STUFF_EN = (STUFF_EN != 0);

    // IDLE: shifter empty; SHIFT: data bits remain; STUFF: a stuff bit is owed
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_STUFF = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [DATA_WIDTH:0]   mem_q [FIFO_DEPTH];   // {last, data}
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q;
    logic [AW-1:0]         rd_ptr_d;
    logic [LW-1:0]         level_q;
    logic [LW-1:0]         level_d;

    logic                  w_ready;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH:0]   w_head;

    // ------------------------------------------------------------------
    // Serializer state
    // ------------------------------------------------------------------
    state_t                state_q;
    logic [DATA_WIDTH-1:0] shreg_q;       // remaining bits, next bit at the output end
    logic                  word_last_q;   // in-flight word closes a packet
    logic [CW-1:0]         cnt_q;         // data bits still to send from shreg_q
    logic [3:0]            ones_q;        // consecutive data ones sent
    logic                  stuff_last_q;  // owed stuff bit carries ser_last
    logic                  ser_data_q;
    logic                  ser_valid_q;
    logic                  ser_stuff_q;
    logic                  ser_last_q;

    // Source of the bit emitted this strobe: the shifter when it still holds
    // bits, otherwise the FIFO head (load-and-emit in the same cycle).
    logic [DATA_WIDTH-1:0] w_src_word;
    logic                  w_src_last;
    logic [CW-1:0]         w_src_cnt;
    logic [DATA_WIDTH-1:0] w_src_next;
    logic                  w_bit;
    logic [CW-1:0]         w_cnt_rem;
    logic                  w_final;
    logic                  w_pkt_end;
    logic [3:0]            w_ones_inc;
    logic [3:0]            w_ones_next;
    logic                  w_run_done;
    logic                  w_have_bits;

    // ------------------------------------------------------------------
    // FIFO handshake. No pass-through: a full FIFO refuses a push even on a
    // cycle that also pops.
    // ------------------------------------------------------------------
    assign w_ready = ~rst && (level_q < C_DEPTH);
    assign w_push  = bus.in_valid && w_ready;
    assign w_pop   = bus.ser_en && (state_q == ST_IDLE) && (level_q != '0);
    assign w_head  = mem_q[rd_ptr_q];

    // Next-state of the FIFO pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO pointer/occupancy registers; reset discards all held words
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {bus.in_last, bus.in_data};
        end
    end

    // ------------------------------------------------------------------
    // Bit selection
    // ------------------------------------------------------------------
    // Pick the word the next data bit comes from
    always_comb begin
        w_src_word = w_head[DATA_WIDTH-1:0];
        w_src_last = w_head[DATA_WIDTH];
        w_src_cnt  = C_WIDTH;
        if (state_q == ST_SHIFT) begin
            w_src_word = shreg_q;
            w_src_last = word_last_q;
            w_src_cnt  = cnt_q;
        end
    end

    generate
        if (LSB_FIRST != 0) begin : g_lsb
            assign w_bit      = w_src_word[0];
            assign w_src_next = {1'b0, w_src_word[DATA_WIDTH-1:1]};
        end else begin : g_msb
            assign w_bit      = w_src_word[DATA_WIDTH-1];
            assign w_src_next = {w_src_word[DATA_WIDTH-2:0], 1'b0};
        end
    endgenerate

    assign w_cnt_rem   = w_src_cnt - CW'(1);
    assign w_final     = (w_cnt_rem == '0);
    assign w_pkt_end   = w_final && w_src_last;
    assign w_ones_inc  = (ones_q >= C_RUN) ? C_RUN : (ones_q + 4'd1);
    assign w_ones_next = (C_STUFF_EN && w_bit) ? w_ones_inc : 4'd0;
    assign w_run_done  = C_STUFF_EN && w_bit && (w_ones_inc == C_RUN);
    assign w_have_bits = (state_q == ST_SHIFT) || (level_q != '0);

    // ------------------------------------------------------------------
    // Serializer FSM with registered outputs; advances only on ser_en
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            word_last_q  <= 1'b0;
            cnt_q        <= '0;
            ones_q       <= 4'd0;
            stuff_last_q <= 1'b0;
            ser_data_q   <= 1'b0;
            ser_valid_q  <= 1'b0;
            ser_stuff_q  <= 1'b0;
            ser_last_q   <= 1'b0;
        end else if (bus.ser_en) begin
            if (state_q == ST_STUFF) begin
                // Owed stuff bit; data position is frozen meanwhile
                ser_data_q   <= 1'b0;
                ser_valid_q  <= 1'b1;
                ser_stuff_q  <= 1'b1;
                ser_last_q   <= stuff_last_q;
                ones_q       <= 4'd0;
                stuff_last_q <= 1'b0;
                state_q      <= (cnt_q != '0) ? ST_SHIFT : ST_IDLE;
            end else if (w_have_bits) begin
                ser_data_q  <= w_bit;
                ser_valid_q <= 1'b1;
                ser_stuff_q <= 1'b0;
                shreg_q     <= w_src_next;
                word_last_q <= w_src_last;
                cnt_q       <= w_cnt_rem;
                if (w_run_done) begin
                    // Run completed: stuff bit follows, and inherits the
                    // end-of-packet mark if this was the packet's last bit
                    ones_q       <= C_RUN;
                    stuff_last_q <= w_pkt_end;
                    ser_last_q   <= 1'b0;
                    state_q      <= ST_STUFF;
                end else if (w_pkt_end) begin
                    // Packet boundary: stuffing never carries across
                    ones_q     <= 4'd0;
                    ser_last_q <= 1'b1;
                    state_q    <= ST_IDLE;
                end else begin
                    ones_q     <= w_ones_next;
                    ser_last_q <= 1'b0;
                    state_q    <= w_final ? ST_IDLE : ST_SHIFT;
                end
            end else begin
                // Underrun: an idle bit time breaks any run of ones
                ser_data_q  <= 1'b0;
                ser_valid_q <= 1'b0;
                ser_stuff_q <= 1'b0;
                ser_last_q  <= 1'b0;
                ones_q      <= 4'd0;
            end
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.ser_data   = ser_data_q;
    assign bus.ser_valid  = ser_valid_q;
    assign bus.ser_stuff  = ser_stuff_q;
    assign bus.ser_last   = ser_last_q;
    assign bus.fifo_level = level_q;

endmodule
`default_nettype wire
